// File: rtl/rvscc_pipeline_pkg.sv
// Shared types for the RV32 five-stage pipeline control logic:
// forwarding select encoding and the load-use sequencer states.
package rvscc_pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } forward_sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    BUBBLE = 1'b1
  } lu_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && count != CNT_MAX) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward control for the five-stage RV32 pipeline, with a
// multi-cycle load-use bubble sequencer, memory-wait freeze and perf counters.
module pipeline_hazard_controller
  import rvscc_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RS     = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           execute_pc_src,
  input  logic                           execute_is_load,
  input  logic [REG_ADDR_W-1:0]          execute_rd,
  input  logic [REG_ADDR_W-1:0]          memory_rd,
  input  logic [REG_ADDR_W-1:0]          writeback_rd,
  input  logic                           memory_reg_write,
  input  logic                           writeback_reg_write,
  input  logic [NUM_RS*REG_ADDR_W-1:0]   decode_rs,
  input  logic [NUM_RS*REG_ADDR_W-1:0]   execute_rs,
  input  logic                           memory_mem_access,
  input  logic                           mem_ready,
  output logic                           fetch_stall,
  output logic                           decode_stall,
  output logic                           execute_stall,
  output logic                           memory_stall,
  output logic                           writeback_stall,
  output logic                           decode_flush,
  output logic                           execute_flush,
  output logic [NUM_RS*2-1:0]            execute_forward,
  output logic [CNT_W-1:0]               cnt_load_use,
  output logic [CNT_W-1:0]               cnt_mem_wait,
  output logic [CNT_W-1:0]               cnt_flush
);

  localparam int                BUB_W    = $clog2(LOAD_STALL + 1);
  localparam logic [BUB_W-1:0]  BUB_LOAD = BUB_W'(LOAD_STALL - 1);
  localparam logic [BUB_W-1:0]  BUB_ONE  = BUB_W'(1);

  lu_state_t        state, state_next;
  logic [BUB_W-1:0] bub_cnt, bub_cnt_next;
  logic             lu_hit;
  logic             mem_wait;
  logic             bubble;
  logic             inc_load_use, inc_mem_wait, inc_flush;

  assign mem_wait = memory_mem_access && !mem_ready;

  // x0 is hard-wired zero, so it is never a forwarding source.
  always_comb begin
    logic [REG_ADDR_W-1:0] rs;
    forward_sel_t          sel;
    execute_forward = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs  = execute_rs[i*REG_ADDR_W +: REG_ADDR_W];
      sel = FWD_REG;
      if (memory_reg_write && rs != '0 && memory_rd == rs) begin
        sel = FWD_MEM;
      end else if (writeback_reg_write && rs != '0 && writeback_rd == rs) begin
        sel = FWD_WB;
      end
      execute_forward[i*2 +: 2] = sel;
    end
  end

  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (decode_rs[i*REG_ADDR_W +: REG_ADDR_W] == execute_rd) begin
        lu_hit = 1'b1;
      end
    end
    lu_hit = lu_hit && execute_is_load && (execute_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bub_cnt <= '0;
    end else begin
      state   <= state_next;
      bub_cnt <= bub_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    bub_cnt_next    = bub_cnt;
    fetch_stall     = 1'b0;
    decode_stall    = 1'b0;
    execute_stall   = 1'b0;
    memory_stall    = 1'b0;
    writeback_stall = 1'b0;
    decode_flush    = 1'b0;
    execute_flush   = 1'b0;
    bubble          = 1'b0;
    inc_mem_wait    = 1'b0;
    inc_flush       = 1'b0;

    if (rst) begin
      decode_flush  = 1'b1;
      execute_flush = 1'b1;
    end else if (mem_wait) begin
      fetch_stall     = 1'b1;
      decode_stall    = 1'b1;
      execute_stall   = 1'b1;
      memory_stall    = 1'b1;
      writeback_stall = 1'b1;
      inc_mem_wait    = 1'b1;
    end else if (execute_pc_src) begin
      decode_flush  = 1'b1;
      execute_flush = 1'b1;
      state_next    = IDLE;
      bub_cnt_next  = '0;
      inc_flush     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (lu_hit) begin
            bubble       = 1'b1;
            bub_cnt_next = BUB_LOAD;
            state_next   = (BUB_LOAD != '0) ? BUBBLE : IDLE;
          end
        end
        BUBBLE: begin
          bubble       = 1'b1;
          bub_cnt_next = bub_cnt - BUB_ONE;
          if (bub_cnt_next == '0) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next   = IDLE;
          bub_cnt_next = '0;
        end
      endcase
    end

    // The first bubble is inserted from IDLE; BUBBLE covers the remaining ones.
    if (bubble) begin
      fetch_stall   = 1'b1;
      decode_stall  = 1'b1;
      execute_flush = 1'b1;
    end
    inc_load_use = bubble;
  end

  hazard_perf_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_load_use),
    .count (cnt_load_use)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_cnt_mem_wait (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_mem_wait),
    .count (cnt_mem_wait)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_flush),
    .count (cnt_flush)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed scenarios then
// random traffic, each cycle's expectation taken from a behavioural model.
module tb_pipeline_hazard_controller;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_RS     = 2;
  localparam int LOAD_STALL = 3;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         execute_pc_src = 1'b0;
  logic                         execute_is_load = 1'b0;
  logic [REG_ADDR_W-1:0]        execute_rd = '0;
  logic [REG_ADDR_W-1:0]        memory_rd = '0;
  logic [REG_ADDR_W-1:0]        writeback_rd = '0;
  logic                         memory_reg_write = 1'b0;
  logic                         writeback_reg_write = 1'b0;
  logic [NUM_RS*REG_ADDR_W-1:0] decode_rs = '0;
  logic [NUM_RS*REG_ADDR_W-1:0] execute_rs = '0;
  logic                         memory_mem_access = 1'b0;
  logic                         mem_ready = 1'b1;
  logic                         fetch_stall, decode_stall, execute_stall;
  logic                         memory_stall, writeback_stall;
  logic                         decode_flush, execute_flush;
  logic [NUM_RS*2-1:0]          execute_forward;
  logic [CNT_W-1:0]             cnt_load_use, cnt_mem_wait, cnt_flush;

  typedef struct packed {
    logic       rst;
    logic       pc_src;
    logic       is_load;
    logic [4:0] ex_rd;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_rw;
    logic       wb_rw;
    logic [4:0] d0;
    logic [4:0] d1;
    logic [4:0] e0;
    logic [4:0] e1;
    logic       mem_acc;
    logic       mem_rdy;
  } stim_t;

  typedef struct packed {
    logic [4:0] stalls;
    logic [1:0] flushes;
    logic [3:0] fwd;
    logic [3:0] lu;
    logic [3:0] mw;
    logic [3:0] fl;
    logic       cnt_valid;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failures = 0;

  int   bubbles_left = 0;
  int   m_lu = 0, m_mw = 0, m_fl = 0;
  bit   cnt_known = 1'b0;

  pipeline_hazard_controller #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_RS     (NUM_RS),
    .LOAD_STALL (LOAD_STALL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .execute_pc_src      (execute_pc_src),
    .execute_is_load     (execute_is_load),
    .execute_rd          (execute_rd),
    .memory_rd           (memory_rd),
    .writeback_rd        (writeback_rd),
    .memory_reg_write    (memory_reg_write),
    .writeback_reg_write (writeback_reg_write),
    .decode_rs           (decode_rs),
    .execute_rs          (execute_rs),
    .memory_mem_access   (memory_mem_access),
    .mem_ready           (mem_ready),
    .fetch_stall         (fetch_stall),
    .decode_stall        (decode_stall),
    .execute_stall       (execute_stall),
    .memory_stall        (memory_stall),
    .writeback_stall     (writeback_stall),
    .decode_flush        (decode_flush),
    .execute_flush       (execute_flush),
    .execute_forward     (execute_forward),
    .cnt_load_use        (cnt_load_use),
    .cnt_mem_wait        (cnt_mem_wait),
    .cnt_flush           (cnt_flush)
  );

  always #5 clk = ~clk;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.mem_rdy = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] fwdModel(input stim_t s, input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (s.mem_rw && s.mem_rd == rs) return 2'b10;
    if (s.wb_rw && s.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must look like.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   frz, hit;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    execute_pc_src      = s.pc_src;
    execute_is_load     = s.is_load;
    execute_rd          = s.ex_rd;
    memory_rd           = s.mem_rd;
    writeback_rd        = s.wb_rd;
    memory_reg_write    = s.mem_rw;
    writeback_reg_write = s.wb_rw;
    decode_rs           = {s.d1, s.d0};
    execute_rs          = {s.e1, s.e0};
    memory_mem_access   = s.mem_acc;
    mem_ready           = s.mem_rdy;

    frz = s.mem_acc && !s.mem_rdy;
    hit = s.is_load && s.ex_rd != 0 && (s.ex_rd == s.d0 || s.ex_rd == s.d1);

    e           = '0;
    e.fwd       = {fwdModel(s, s.e1), fwdModel(s, s.e0)};
    e.lu        = 4'(m_lu);
    e.mw        = 4'(m_mw);
    e.fl        = 4'(m_fl);
    e.cnt_valid = cnt_known;

    if (s.rst) begin
      e.flushes    = 2'b11;
      bubbles_left = 0;
      m_lu = 0; m_mw = 0; m_fl = 0;
      cnt_known    = 1'b1;
    end else if (frz) begin
      e.stalls = 5'b11111;
      m_mw     = sat(m_mw + 1);
    end else if (s.pc_src) begin
      e.flushes    = 2'b11;
      bubbles_left = 0;
      m_fl         = sat(m_fl + 1);
    end else if (bubbles_left > 0 || hit) begin
      e.stalls     = 5'b11000;
      e.flushes    = 2'b01;
      bubbles_left = (bubbles_left > 0) ? bubbles_left - 1 : LOAD_STALL - 1;
      m_lu         = sat(m_lu + 1);
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("stalls", 32'({fetch_stall, decode_stall, execute_stall,
                                 memory_stall, writeback_stall}), 32'(e.stalls));
      checkOutput("flushes", 32'({decode_flush, execute_flush}), 32'(e.flushes));
      checkOutput("forward", 32'(execute_forward), 32'(e.fwd));
      if (e.cnt_valid) begin
        checkOutput("cnt_load_use", 32'(cnt_load_use), 32'(e.lu));
        checkOutput("cnt_mem_wait", 32'(cnt_mem_wait), 32'(e.mw));
        checkOutput("cnt_flush", 32'(cnt_flush), 32'(e.fl));
      end
    end
  end

  initial begin
    stim_t s;

    s = idleStim();
    s.rst = 1'b1;
    repeat (3) applyStimulus(s);
    s.rst = 1'b0;
    applyStimulus(s);

    s = idleStim();
    s.mem_rd = 5; s.wb_rd = 5; s.mem_rw = 1'b1; s.wb_rw = 1'b1;
    s.e0 = 5; s.e1 = 0;
    applyStimulus(s);
    s.mem_rw = 1'b0;
    applyStimulus(s);

    s = idleStim();
    s.is_load = 1'b1; s.ex_rd = 7; s.d1 = 7;
    applyStimulus(s);
    repeat (4) applyStimulus(idleStim());

    s = idleStim();
    s.is_load = 1'b1; s.ex_rd = 7; s.d0 = 7;
    applyStimulus(s);
    s = idleStim();
    s.pc_src = 1'b1;
    applyStimulus(s);
    repeat (2) applyStimulus(idleStim());

    s = idleStim();
    s.pc_src = 1'b1; s.mem_acc = 1'b1; s.mem_rdy = 1'b0;
    repeat (4) applyStimulus(s);
    s.mem_rdy = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());

    s = idleStim();
    s.mem_acc = 1'b1; s.mem_rdy = 1'b0;
    repeat (20) applyStimulus(s);
    applyStimulus(idleStim());

    for (int n = 0; n < 600; n++) begin
      s         = idleStim();
      s.rst     = ($urandom_range(0, 79) == 0);
      s.pc_src  = ($urandom_range(0, 9) == 0);
      s.is_load = $urandom_range(0, 1) == 1;
      s.ex_rd   = 5'($urandom_range(0, 3));
      s.mem_rd  = 5'($urandom_range(0, 3));
      s.wb_rd   = 5'($urandom_range(0, 3));
      s.mem_rw  = $urandom_range(0, 1) == 1;
      s.wb_rw   = $urandom_range(0, 1) == 1;
      s.d0      = 5'($urandom_range(0, 3));
      s.d1      = 5'($urandom_range(0, 3));
      s.e0      = 5'($urandom_range(0, 3));
      s.e1      = 5'($urandom_range(0, 3));
      s.mem_acc = ($urandom_range(0, 3) == 0);
      s.mem_rdy = $urandom_range(0, 1) == 1;
      applyStimulus(s);
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
